// File: rtl/aes_inv_mixcol_seq_pkg.sv
// Shared AES helpers: FSM states, GF(2^8) arithmetic,
// and the MixColumns / InvMixColumns coefficient rows.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  GF_POLY  = 8'h1B;
  localparam logic [31:0] INV_COEF = 32'h0e0b0d09;
  localparam logic [31:0] FWD_COEF = 32'h02030101;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_mixcol_seq_if.sv
// Valid/ready bundle carrying one 128-bit AES state
// in each direction.
interface aes_inv_mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_mixcol_seq_col.sv
// Combinational single-column (Inv)MixColumns transform.
// Byte 0 of the column sits in the MSBs.
module aes_inv_mixcol_col
  import aes_pkg::*;
#(
  parameter int INVERSE = 1
) (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  localparam logic [31:0] COEF =
    (INVERSE != 0) ? INV_COEF : FWD_COEF;

  // Row r uses the coefficient row rotated right by r.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        col_out[31-8*r -: 8] = col_out[31-8*r -: 8] ^
          gf_mul(col_in[31-8*j -: 8],
                 COEF[31-8*((j-r)&3) -: 8]);
      end
    end
  end

endmodule

// File: rtl/aes_inv_mixcol_seq.sv
// Sequential (Inv)MixColumns: one column per cycle
// through a single shared column transform.
module aes_inv_mixcol_seq
  import aes_pkg::*;
#(
  parameter int INVERSE = 1
) (
  input logic                 clk,
  input logic                 rst,
  aes_inv_mixcol_seq_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        col;
  logic [3:0][31:0]  cap_q;
  logic [3:0][31:0]  res_q;
  logic [31:0]       col_in;
  logic [31:0]       col_out;
  logic              hs;

  assign hs            = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = res_q;

  // Column 0 is the top word, hence the 3-col index.
  assign col_in = cap_q[2'd3 - col];

  aes_inv_mixcol_col #(
    .INVERSE(INVERSE)
  ) u_col (
    .col_in (col_in),
    .col_out(col_out)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid)  state_nx = BUSY;
      BUSY: if (col == 2'd3)   state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      cap_q <= '0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        cap_q <= bus.in_data;
        col   <= '0;
      end
      if (state == BUSY) begin
        res_q[2'd3 - col] <= col_out;
        col               <= col + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_mixcol_seq.sv
// Scoreboard bench for aes_inv_mixcol_seq: forward and
// inverse instances, vectors, backpressure, reset, round trip.
module tb_aes_inv_mixcol_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [127:0] exp_fwd [$];
  logic [127:0] exp_inv [$];

  always #5 clk = ~clk;

  aes_inv_mixcol_seq_if fi ();
  aes_inv_mixcol_seq_if ii ();

  aes_inv_mixcol_seq #(.INVERSE(0)) dut_fwd (
    .clk(clk),
    .rst(rst),
    .bus(fi.slave)
  );

  aes_inv_mixcol_seq #(.INVERSE(1)) dut_inv (
    .clk(clk),
    .rst(rst),
    .bus(ii.slave)
  );

  function automatic logic [7:0] m_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] m_mix(
    input logic [127:0] s,
    input bit           inv
  );
    logic [7:0]   c [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] o;
    if (inv) c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     c = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++)
        a[j] = s[127 - 32*k - 8*j -: 8];
      for (int r = 0; r < 4; r++) begin
        b = '0;
        for (int j = 0; j < 4; j++)
          b = b ^ m_mul(a[j], c[(j - r + 4) % 4]);
        o[127 - 32*k - 8*r -: 8] = b;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_in(input bit sel, input logic v,
                        input logic [127:0] d);
    if (sel) begin ii.in_valid = v; ii.in_data = d; end
    else     begin fi.in_valid = v; fi.in_data = d; end
  endtask

  // Drive one state and wait for its result; lat = 0 on timeout.
  task automatic xfer(input bit sel, input logic [127:0] d,
                      output logic [127:0] q, output int lat,
                      output logic ov_after);
    logic ov;
    lat = 0;
    q = 'x;
    set_in(sel, 1'b1, d);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) set_in(sel, 1'b0, d);
      ov = sel ? ii.out_valid : fi.out_valid;
      if (ov) begin
        lat = i;
        q = sel ? ii.out_data : fi.out_data;
        break;
      end
    end
    @(negedge clk);
    ov_after = sel ? ii.out_valid : fi.out_valid;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (ii.out_valid !== 1'b0 || fi.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid got %b/%b want 0/0",
               fi.out_valid, ii.out_valid);
    end
    n_cmp++;
    if (ii.out_data !== '0 || fi.out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_out_data got %h/%h want 0",
               fi.out_data, ii.out_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ii.in_ready !== 1'b1 || fi.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b/%b want 1/1",
               fi.in_ready, ii.in_ready);
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      ii.out_ready = i[0];
      @(negedge clk);
      if (ii.out_valid !== 1'b0) bad++;
    end
    ii.out_ready = 1'b1;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL idle_no_out got %0d valid cycles want 0", bad);
    end
  endtask

  task automatic test_inv_vector();
    logic [127:0] d, q, e;
    int lat;
    logic ova;
    d = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    exp_inv.push_back(m_mix(d, 1'b1));
    xfer(1'b1, d, q, lat, ova);
    e = exp_inv.pop_front();
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL inv_latency got %0d want 5", lat);
    end
    n_cmp++;
    if (q !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
      n_bad++;
      $display("FAIL inv_vector got %h want db135345f20a225c01010101c6c6c6c6", q);
    end
    n_cmp++;
    if (q !== e) begin
      n_bad++;
      $display("FAIL inv_model got %h want %h", q, e);
    end
    n_cmp++;
    if (ova !== 1'b0 || ii.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL inv_one_cycle got ov=%b rdy=%b want 0/1",
               ova, ii.in_ready);
    end
  endtask

  task automatic test_fwd_vector();
    logic [127:0] d, q, e;
    int lat;
    logic ova;
    d = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    exp_fwd.push_back(m_mix(d, 1'b0));
    xfer(1'b0, d, q, lat, ova);
    e = exp_fwd.pop_front();
    n_cmp++;
    if (q !== 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8) begin
      n_bad++;
      $display("FAIL fwd_vector got %h want 8e4da1bc9fdc589dd5d5d7d64d7ebdf8", q);
    end
    n_cmp++;
    if (q !== e || lat !== 5) begin
      n_bad++;
      $display("FAIL fwd_model got %h lat %0d want %h lat 5", q, lat, e);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, first, e;
    int lat;
    int bad;
    d = rnd128();
    exp_inv.push_back(m_mix(d, 1'b1));
    ii.out_ready = 1'b0;
    set_in(1'b1, 1'b1, d);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, ~d);
      if (ii.out_valid) begin lat = i; break; end
    end
    first = ii.out_data;
    e = exp_inv.pop_front();
    n_cmp++;
    if (lat !== 5 || first !== e) begin
      n_bad++;
      $display("FAIL bp_result got %h lat %0d want %h lat 5",
               first, lat, e);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ii.out_valid !== 1'b1 || ii.out_data !== first ||
          ii.in_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    end
    set_in(1'b1, 1'b0, d);
    ii.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ii.out_valid !== 1'b0 || ii.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release got ov=%b rdy=%b want 0/1",
               ii.out_valid, ii.in_ready);
    end
  endtask

  task automatic test_reset_busy();
    logic [127:0] d, q, e;
    int lat;
    logic ova;
    d = rnd128();
    exp_inv.push_back(m_mix(d, 1'b1));
    set_in(1'b1, 1'b1, d);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_in(1'b1, 1'b0, d);
    end
    rst = 1'b1;
    exp_inv.delete();
    #1;
    n_cmp++;
    if (ii.out_valid !== 1'b0 || ii.out_data !== '0) begin
      n_bad++;
      $display("FAIL rst_busy got ov=%b data=%h want 0/0",
               ii.out_valid, ii.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    d = rnd128();
    exp_inv.push_back(m_mix(d, 1'b1));
    xfer(1'b1, d, q, lat, ova);
    e = exp_inv.pop_front();
    n_cmp++;
    if (q !== e || lat !== 5) begin
      n_bad++;
      $display("FAIL rst_recover got %h lat %0d want %h lat 5",
               q, lat, e);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [127:0] e;
    int sent, outs, cyc, last;
    sent = 0;
    outs = 0;
    last = -1;
    ii.out_ready = 1'b1;
    for (cyc = 0; cyc < 120 && outs < N; cyc++) begin
      if (ii.out_valid) begin
        e = exp_inv.size() ? exp_inv.pop_front() : 'x;
        n_cmp++;
        if (ii.out_data !== e) begin
          n_bad++;
          $display("FAIL b2b_data[%0d] got %h want %h",
                   outs, ii.out_data, e);
        end
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last !== 6) begin
            n_bad++;
            $display("FAIL b2b_gap[%0d] got %0d want 6",
                     outs, cyc - last);
          end
        end
        last = cyc;
        outs++;
      end
      if (ii.in_ready && sent < N) begin
        ii.in_data = rnd128();
        exp_inv.push_back(m_mix(ii.in_data, 1'b1));
        sent++;
      end
      ii.in_valid = 1'b1;
      @(negedge clk);
    end
    ii.in_valid = 1'b0;
    n_cmp++;
    if (outs !== N || exp_inv.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_count got %0d outs %0d left want %0d/0",
               outs, exp_inv.size(), N);
    end
    @(negedge clk);
    @(negedge clk);
    exp_inv.delete();
  endtask

  task automatic test_roundtrip();
    logic [127:0] d, mid, q, e;
    int lat1, lat2;
    logic ova;
    int bad_f, bad_r;
    bad_f = 0;
    bad_r = 0;
    fi.out_ready = 1'b1;
    ii.out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      d = rnd128();
      exp_fwd.push_back(m_mix(d, 1'b0));
      xfer(1'b0, d, mid, lat1, ova);
      e = exp_fwd.pop_front();
      if (mid !== e || lat1 !== 5) bad_f++;
      exp_inv.push_back(d);
      xfer(1'b1, mid, q, lat2, ova);
      e = exp_inv.pop_front();
      if (q !== e || lat2 !== 5) begin
        bad_r++;
        if (bad_r < 4)
          $display("FAIL roundtrip[%0d] got %h want %h", n, q, e);
      end
    end
    n_cmp++;
    if (bad_f !== 0) begin
      n_bad++;
      $display("FAIL rt_forward got %0d bad want 0", bad_f);
    end
    n_cmp++;
    if (bad_r !== 0) begin
      n_bad++;
      $display("FAIL rt_inverse got %0d bad want 0", bad_r);
    end
  endtask

  initial begin
    fi.in_valid  = 1'b0;
    fi.in_data   = '0;
    fi.out_ready = 1'b1;
    ii.in_valid  = 1'b0;
    ii.in_data   = '0;
    ii.out_ready = 1'b1;
    test_reset();
    test_inv_vector();
    test_fwd_vector();
    test_idle();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_mixcol_seq.md
AES_INV_MIXCOL_SEQ -- requirements
Module: aes_inv_mixcol_seq

Interface
REQ-001 Parameter INVERSE, default 1, 1 = InvMixColumns (decrypt direction), 0 = forward MixColumns (self-check/encrypt direction).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  in_data holds a state to transform.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 in_data  input  128  AES state; column c = bits [127-32c -: 32], byte 0 of a column is its MSB.
REQ-007 out_valid  output  1  out_data holds a result.
REQ-008 out_ready  input  1  consumer accepts out_data.
REQ-009 out_data  output  128  transformed state, same byte/column layout as in_data.

Function
REQ-010 FSM states IDLE, BUSY, DONE; 2-bit column counter col.
REQ-011 in_ready SHALL be 1 only in IDLE; input handshake = in_valid && in_ready.
REQ-012 On input handshake: capture in_data into an internal 128-bit register, col <= 0, IDLE -> BUSY.
REQ-013 In BUSY, one column per cycle: column col of the capture register is transformed and written to column col of the result register; col increments.
REQ-014 BUSY -> DONE when col = 3 is processed; col wraps to 0.
REQ-015 Latency: handshake in cycle t -> out_valid = 1 in cycle t+5.
REQ-016 out_valid SHALL be 1 only in DONE; DONE -> IDLE when out_ready = 1.
REQ-017 out_data SHALL be registered and held stable while out_valid && !out_ready.
REQ-018 No new input accepted in BUSY or DONE (in_ready = 0); in_valid then has no effect.
REQ-019 out_ready and in_valid asserted together in DONE: output consumed, input NOT accepted that cycle; accepted next cycle in IDLE.
REQ-020 INVERSE = 1 per column (a0..a3): b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3, rows rotate coefficients right by one per byte.
REQ-021 INVERSE = 0: b0 = 02·a0 ^ 03·a1 ^ 01·a2 ^ 01·a3, same rotation.
REQ-022 GF(2^8) multiplication modulo x^8+x^4+x^3+x+1 (0x11B), built from xtime; all results exactly 8 bits.
REQ-023 out_valid stays 0 indefinitely if no input arrives; out_ready ignored outside DONE.

Reset
REQ-024 rst = 1 forces IDLE, col = 0, capture/result registers = 0, out_valid = 0, out_data = 0, in_ready = 1 after release.
REQ-025 rst asserted in BUSY or DONE discards the in-flight state; no partial result is ever presented.
REQ-026 First handshake accepted in the first rising edge with rst = 0 and in_valid = 1.

Structure
REQ-027 Shared package aes_pkg holds: FSM state enum, GF polynomial constant 8'h1B, xtime and gf_mul functions, column-coefficient constants.
REQ-028 One sub-module aes_inv_mixcol_col: purely combinational 32-bit column transform, parameter INVERSE, instanced once and time-multiplexed by col.

Verification
REQ-029 INVERSE=1, in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_ready=1 -> out_data = db135345_f20a225c_01010101_c6c6c6c6, out_valid at t+5 for exactly one cycle.
REQ-030 INVERSE=0, in_data = db135345_f20a225c_d4d4d4d5_2d26314c -> out_data = 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8.
REQ-031 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-032 rst pulse in BUSY (col=2) -> out_valid=0, out_data=0 immediately; next input after release yields correct result with t+5 latency.
REQ-033 Back-to-back in_valid=1 held constantly with out_ready=1 -> one result every 6 cycles, in_ready=0 in BUSY/DONE, no input dropped or duplicated.
REQ-034 Random round-trip: 1000 random states through INVERSE=0 instance then INVERSE=1 instance -> output equals original input bit-exact.
